hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the four-stage IF/ID/EX/WB processor datapath.
- Detects read-after-write hazards between the instruction in ID and the older instructions in EX and WB; stalls fetch/decode and inserts bubbles into ID/EX.
- Squashes all younger instructions when WB resolves a taken branch or jump (predict-not-taken).
- Keeps its own shadow scoreboard of the EX and WB slots, plus saturating stall/flush event counters.

---
 rtl/hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Sequencing controller for a four-stage IF/ID/EX/WB pipeline. It tracks the
// destination registers of the instructions now in EX and WB in a private
// shadow scoreboard. When the instruction in ID reads one of those registers,
// it stalls fetch/decode and feeds bubbles into ID/EX. A taken branch or jump
// resolved in WB squashes every younger instruction; fetch is predict-not-taken.
// Two saturating counters record stall cycles and flushes.
//
// Ports
//   clock            pipeline clock, all state changes on the rising edge
//   reset            synchronous, active-high
//   id_valid         ID stage holds a real instruction
//   id_rs / id_rt    source specifiers of the ID instruction
//   id_rd            destination specifier of the ID instruction
//   id_uses_rs/rt    ID instruction actually reads rs / rt
//   id_reg_wrt       ID instruction writes rd
//   wb_branch_taken  WB stage resolved a taken branch/jump
//   pc_en            PC load enable
//   if_id_en         IF/ID load enable
//   id_ex_bubble     load a NOP into ID/EX
//   flush            clear IF/ID and ID/EX at this edge
//   state            RUN=0, STALL=1, FLUSH=2
//   stall_cycles     saturating count of RAW-stall cycles
//   flush_count      saturating count of taken-branch flushes
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REG_ADDR_W = 6,
   parameter int CNT_W      = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  id_reg_wrt,
   input  logic                  wb_branch_taken,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_bubble,
   output logic                  flush,
   output logic [1:0]            state,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    ex_v_q, ex_v_d;
   logic                    ex_w_q, ex_w_d;
   logic [REG_ADDR_W-1:0]   ex_dst_q, ex_dst_d;
   logic                    wb_v_q, wb_v_d;
   logic                    wb_w_q, wb_w_d;
   logic [REG_ADDR_W-1:0]   wb_dst_q, wb_dst_d;
   logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;

   logic                    in_flush;
   logic                    raw;
   logic                    issue;
   logic                    taken;

   // Per-operand hazard match. Register 0 is compared like any other
   // specifier; the datapath has no hardwired zero register.
   logic [REG_ADDR_W-1:0]   src_addr [2];
   logic [1:0]              src_used;
   logic [1:0]              src_hit;

   assign src_addr[0] = id_rs;
   assign src_addr[1] = id_rt;
   assign src_used    = {id_uses_rt, id_uses_rs};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         // The register file has no write-through, so a producer still in WB
         // blocks just as one in EX does.
         assign src_hit[gi] = src_used[gi] &
                              ((ex_v_q & ex_w_q & (ex_dst_q == src_addr[gi])) |
                               (wb_v_q & wb_w_q & (wb_dst_q == src_addr[gi])));
      end
   endgenerate

   // IF/ID holds a squashed NOP during FLUSH, so ID contents are ignored there.
   assign in_flush = (state_q == ST_FLUSH);
   assign taken    = wb_branch_taken;
   assign raw      = id_valid & ~in_flush & (|src_hit);
   assign issue    = id_valid & ~raw & ~in_flush & ~taken;

   // Pipeline control outputs (Mealy). Reset dominates, then taken, then raw.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_bubble = ~issue;
      flush        = 1'b0;
      if (reset) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (taken) begin
         id_ex_bubble = 1'b1;
         flush        = 1'b1;
      end else if (raw) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   // Next-state, shadow scoreboard and counters.
   always_comb begin
      state_d     = state_q;
      ex_v_d      = ex_v_q;
      ex_w_d      = ex_w_q;
      ex_dst_d    = ex_dst_q;
      wb_v_d      = wb_v_q;
      wb_w_d      = wb_w_q;
      wb_dst_d    = wb_dst_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (taken) begin
         state_d = ST_FLUSH;
         ex_v_d  = 1'b0;
         wb_v_d  = 1'b0;
         if (flush_cnt_q != {CNT_W{1'b1}}) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end else begin
         wb_v_d   = ex_v_q;
         wb_w_d   = ex_w_q;
         wb_dst_d = ex_dst_q;
         if (issue) begin
            ex_v_d   = 1'b1;
            ex_w_d   = id_reg_wrt;
            ex_dst_d = id_rd;
         end else begin
            ex_v_d   = 1'b0;
            ex_w_d   = 1'b0;
            ex_dst_d = '0;
         end

         case (state_q)
            ST_RUN:   state_d = raw ? ST_STALL : ST_RUN;
            ST_STALL: state_d = raw ? ST_STALL : ST_RUN;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase

         if (raw && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_RUN;
         ex_v_q      <= 1'b0;
         ex_w_q      <= 1'b0;
         ex_dst_q    <= '0;
         wb_v_q      <= 1'b0;
         wb_w_q      <= 1'b0;
         wb_dst_q    <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ex_v_q      <= ex_v_d;
         ex_w_q      <= ex_w_d;
         ex_dst_q    <= ex_dst_d;
         wb_v_q      <= wb_v_d;
         wb_w_q      <= wb_w_d;
         wb_dst_q    <= wb_dst_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign state        = state_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Each cycle, the stimulus task drives ID
// and branch inputs. A reference model then computes the expected outputs and
// pushes them to a queue. At the falling edge the DUT outputs are sampled and
// compared with the entry popped from the queue. Directed scenarios then check
// stall counts and counter values against fixed numbers. The counters are
// 8 bits wide here so saturation is reached in a few hundred cycles.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int AW = 6;
   localparam int CW = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          id_valid;
   logic [AW-1:0] id_rs, id_rt, id_rd;
   logic          id_uses_rs, id_uses_rt, id_reg_wrt;
   logic          wb_branch_taken;
   logic          pc_en, if_id_en, id_ex_bubble, flush;
   logic [1:0]    state;
   logic [CW-1:0] stall_cycles, flush_count;

   hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clock          (clock),
      .reset          (reset),
      .id_valid       (id_valid),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_rd          (id_rd),
      .id_uses_rs     (id_uses_rs),
      .id_uses_rt     (id_uses_rt),
      .id_reg_wrt     (id_reg_wrt),
      .wb_branch_taken(wb_branch_taken),
      .pc_en          (pc_en),
      .if_id_en       (if_id_en),
      .id_ex_bubble   (id_ex_bubble),
      .flush          (flush),
      .state          (state),
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
   );

   always #5 clock = ~clock;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct packed {
      logic          pc_en;
      logic          if_id_en;
      logic          bub;
      logic          flush;
      logic [1:0]    st;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
      logic          full;   // state/counters known (a reset edge has happened)
   } exp_t;

   exp_t exp_q [$];

   // Reference model state
   bit            m_known = 1'b0;
   logic [1:0]    m_state;
   bit            m_ex_v, m_ex_w, m_wb_v, m_wb_w;
   logic [AW-1:0] m_ex_dst, m_wb_dst;
   logic [CW-1:0] m_sc, m_fc;

   // Observed values from the last step
   logic          o_pc_en, o_bub, o_flush;
   logic [1:0]    o_state;

   task automatic step(input bit rst, input bit v,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                       input bit urs, input bit urt, input bit wr, input bit br);
      exp_t e;
      bit   hit_rs, hit_rt, r_raw, r_iss;
      reset = rst; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
      id_uses_rs = urs; id_uses_rt = urt; id_reg_wrt = wr; wb_branch_taken = br;

      hit_rs = urs && ((m_ex_v && m_ex_w && m_ex_dst == rs) || (m_wb_v && m_wb_w && m_wb_dst == rs));
      hit_rt = urt && ((m_ex_v && m_ex_w && m_ex_dst == rt) || (m_wb_v && m_wb_w && m_wb_dst == rt));
      r_raw  = v && (m_state != 2'd2) && (hit_rs || hit_rt);
      r_iss  = v && !r_raw && (m_state != 2'd2) && !br;

      if (rst)        {e.pc_en, e.if_id_en, e.bub, e.flush} = 4'b0010;
      else if (br)    {e.pc_en, e.if_id_en, e.bub, e.flush} = 4'b1111;
      else if (r_raw) {e.pc_en, e.if_id_en, e.bub, e.flush} = 4'b0010;
      else            {e.pc_en, e.if_id_en, e.bub, e.flush} = {2'b11, !r_iss, 1'b0};
      e.st = m_state; e.sc = m_sc; e.fc = m_fc; e.full = m_known;
      exp_q.push_back(e);

      @(negedge clock);
      e = exp_q.pop_front();
      o_pc_en = pc_en; o_bub = id_ex_bubble; o_flush = flush; o_state = state;
      check_eq("pc_en",        32'(pc_en),        32'(e.pc_en));
      check_eq("if_id_en",     32'(if_id_en),     32'(e.if_id_en));
      check_eq("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bub));
      check_eq("flush",        32'(flush),        32'(e.flush));
      if (e.full) begin
         check_eq("state",        32'(state),        32'(e.st));
         check_eq("stall_cycles", 32'(stall_cycles), 32'(e.sc));
         check_eq("flush_count",  32'(flush_count),  32'(e.fc));
      end

      @(posedge clock);
      if (rst) begin
         m_known = 1'b1; m_state = 2'd0;
         m_ex_v = 0; m_wb_v = 0; m_ex_w = 0; m_wb_w = 0; m_ex_dst = '0; m_wb_dst = '0;
         m_sc = '0; m_fc = '0;
      end else if (br) begin
         m_state = 2'd2; m_ex_v = 0; m_wb_v = 0;
         if (m_fc != '1) m_fc = m_fc + 1'b1;
      end else begin
         m_wb_v = m_ex_v; m_wb_w = m_ex_w; m_wb_dst = m_ex_dst;
         m_ex_v = r_iss; m_ex_w = r_iss && wr; m_ex_dst = r_iss ? rd : '0;
         m_state = r_raw ? 2'd1 : 2'd0;
         if (r_raw && m_sc != '1) m_sc = m_sc + 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      step(0, 0, '0, '0, '0, 0, 0, 0, 0);
   endtask

   task automatic writer(input logic [AW-1:0] rd);
      step(0, 1, '0, '0, rd, 0, 0, 1, 0);
   endtask

   // Holds one reader in ID until it issues; bounded so a stuck stall ends.
   task automatic reader(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input bit urs, input bit urt, output int stalls, output bit issued);
      stalls = 0; issued = 0;
      for (int k = 0; k < 8 && !issued; k++) begin
         step(0, 1, rs, rt, 6'd0, urs, urt, 0, 0);
         if (!o_pc_en) stalls++;
         if (!o_bub) issued = 1;
      end
   endtask

   int          n_st;
   bit          iss;
   logic [CW-1:0] sc0;

   initial begin
      m_state = 2'd0; m_ex_v = 0; m_wb_v = 0; m_ex_w = 0; m_wb_w = 0;
      m_ex_dst = '0; m_wb_dst = '0; m_sc = '0; m_fc = '0;

      // Reset for three cycles with random ID/branch inputs
      for (int k = 0; k < 3; k++)
         step(1, 1'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      idle();
      check_eq("post_reset_state", 32'(o_state), 32'd0);
      check_eq("post_reset_pc_en", 32'(o_pc_en), 32'd1);

      // Back-to-back RAW on r5
      writer(6'd5);
      reader(6'd5, 6'd0, 1, 0, n_st, iss);
      check_eq("b2b_stalls", 32'(n_st), 32'd2);
      check_eq("b2b_issue", 32'(iss), 32'd1);
      check_eq("b2b_stall_cnt", 32'(stall_cycles), 32'd2);

      // Register 0 is tracked like any other register
      idle(); idle();
      writer(6'd0);
      reader(6'd0, 6'd9, 1, 0, n_st, iss);
      check_eq("r0_stalls", 32'(n_st), 32'd2);

      // Distance-2 RAW on rt=63
      idle(); idle();
      sc0 = stall_cycles;
      writer(6'd63);
      step(0, 1, 6'd1, 6'd2, 6'd10, 1, 1, 1, 0);
      reader(6'd0, 6'd63, 0, 1, n_st, iss);
      check_eq("d2_stalls", 32'(n_st), 32'd1);
      check_eq("d2_stall_delta", 32'(stall_cycles - sc0), 32'd1);

      // Distance-3: no stall
      idle(); idle();
      writer(6'd20);
      step(0, 1, 6'd1, 6'd2, 6'd11, 1, 1, 0, 0);
      step(0, 1, 6'd1, 6'd2, 6'd12, 1, 1, 0, 0);
      reader(6'd20, 6'd0, 1, 0, n_st, iss);
      check_eq("d3_stalls", 32'(n_st), 32'd0);

      // rt=63 not used -> no stall
      idle(); idle();
      writer(6'd63);
      reader(6'd0, 6'd63, 0, 0, n_st, iss);
      check_eq("unused_rt_stalls", 32'(n_st), 32'd0);

      // Non-writer with dst=7
      idle(); idle();
      step(0, 1, 6'd0, 6'd0, 6'd7, 0, 0, 0, 0);
      reader(6'd7, 6'd7, 1, 1, n_st, iss);
      check_eq("nonwriter_stalls", 32'(n_st), 32'd0);

      // id_valid=0 with a matching source: no stall, bubble
      idle(); idle();
      writer(6'd4);
      step(0, 0, 6'd4, 6'd4, 6'd0, 1, 1, 0, 0);
      check_eq("invalid_pc_en", 32'(o_pc_en), 32'd1);
      check_eq("invalid_bubble", 32'(o_bub), 32'd1);

      // Taken branch in the 2nd stall cycle
      idle(); idle();
      sc0 = stall_cycles;
      writer(6'd3);
      step(0, 1, 6'd3, 6'd0, 6'd0, 1, 0, 0, 0);
      check_eq("tk_first_stall", 32'(o_pc_en), 32'd0);
      step(0, 1, 6'd3, 6'd0, 6'd0, 1, 0, 0, 1);
      check_eq("tk_flush", 32'(o_flush), 32'd1);
      check_eq("tk_stall_delta", 32'(stall_cycles - sc0), 32'd1);
      check_eq("tk_flush_cnt", 32'(flush_count), 32'd1);
      step(0, 1, 6'd3, 6'd0, 6'd0, 1, 0, 1, 0);
      check_eq("tk_state_flush", 32'(o_state), 32'd2);
      check_eq("tk_flush_bubble", 32'(o_bub), 32'd1);
      reader(6'd3, 6'd0, 1, 0, n_st, iss);
      check_eq("tk_slots_empty", 32'(n_st), 32'd0);

      // Reset during a stall abandons it
      writer(6'd8);
      step(0, 1, 6'd8, 6'd0, 6'd0, 1, 0, 0, 0);
      step(1, 1, 6'd8, 6'd0, 6'd0, 1, 0, 0, 0);
      idle();
      check_eq("rst_stall_cnt", 32'(stall_cycles), 32'd0);
      check_eq("rst_state", 32'(o_state), 32'd0);

      // Reset during FLUSH
      step(0, 0, '0, '0, '0, 0, 0, 0, 1);
      step(1, 0, '0, '0, '0, 0, 0, 0, 0);
      idle();
      check_eq("rst_flush_cnt", 32'(flush_count), 32'd0);

      // Stall counter saturation
      for (int k = 0; k < 140; k++) begin
         writer(6'd1);
         reader(6'd1, 6'd0, 1, 0, n_st, iss);
      end
      check_eq("stall_sat", 32'(stall_cycles), 32'(8'hFF));

      // Flush counter saturation (back-to-back taken)
      for (int k = 0; k < 300; k++)
         step(0, 1'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1);
      idle();
      check_eq("flush_sat", 32'(flush_count), 32'(8'hFF));
      check_eq("stall_hold", 32'(stall_cycles), 32'(8'hFF));

      // Random traffic checked against the model
      for (int k = 0; k < 400; k++)
         step(($urandom_range(0, 49) == 0), 1'($urandom), 6'($urandom_range(0, 3)),
              6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 1'($urandom),
              1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
